pc_unit: RTL

//   Program-counter stage that consumes NextPCSrc from the branch unit and selects the next PC.

---
 rtl/pc_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter stage: selects PC+4 or the branch target, sequences instruction
// fetch with a req/rdy handshake, traps misaligned taken targets and counts retirements.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        NextPCSrc,
  input  logic [31:0] BrTarget,
  input  logic        pc_en,
  input  logic        imem_rdy,
  output logic [31:0] PC,
  output logic [31:0] PCInc,
  output logic        fetch_req,
  output logic        instr_vld,
  output logic        misalign,
  output logic [31:0] trap_pc,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    EXEC,
    TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] instret_q, instret_d;

  logic [31:0] pc_inc;
  logic [31:0] tgt;
  logic        bad;

  // JALR semantics: bit 0 of the target is always dropped; only bit 1 can misalign.
  assign tgt    = BrTarget & ~32'd1;
  assign bad    = NextPCSrc & tgt[1];
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      trap_pc_q <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_pc_q <= trap_pc_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    instret_d = instret_q;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (imem_rdy) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (pc_en) begin
          if (bad) begin
            trap_pc_d = pc_q;
            state_d   = TRAP;
          end else begin
            pc_d      = NextPCSrc ? tgt : pc_inc;
            instret_d = instret_q + 32'd1;
            state_d   = FETCH;
          end
        end
      end
      TRAP: begin
        pc_d    = TRAP_VEC;
        state_d = FETCH;
      end
    endcase
  end

  // Handshake and status outputs decode straight from state, so async reset clears them.
  assign fetch_req = (state_q == FETCH);
  assign instr_vld = (state_q == EXEC);
  assign misalign  = (state_q == TRAP);
  assign PC        = pc_q;
  assign PCInc     = pc_inc;
  assign trap_pc   = trap_pc_q;
  assign instret   = instret_q;

endmodule
